uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL derive DIV = CLK_FREQ/(BAUD*16), integer-truncated, as the 16x oversample divisor; DIV >= 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port rx_enable, input, 1 bit: receiver enable (driven from UART_CON[1]).
REQ-008 SHALL have port rd_en, input, 1 bit: pop one byte from the FIFO head.
REQ-009 SHALL have port err_clr, input, 1 bit: clear sticky error flags.
REQ-010 SHALL have port rx_data, output, 8 bits: FIFO head byte; 8'h00 when empty.
REQ-011 SHALL have port rx_valid, output, 1 bit: FIFO non-empty.
REQ-012 SHALL have port rx_overflow, output, 1 bit: sticky, byte dropped on full FIFO.
REQ-013 SHALL have port frame_err, output, 1 bit: sticky, stop bit sampled low.
REQ-014 SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-015 SHALL pass rxd through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rxs.
REQ-016 SHALL run a free-running tick counter 0..DIV-1, emitting a one-clk tick when at DIV-1, then wrapping to 0.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP with a 4-bit sample counter sc and a 3-bit bit index bi.
REQ-018 IDLE: on a clk where rx_enable=1 and rxs falls (previous 1, current 0), SHALL go to START with sc=0.
REQ-019 START: SHALL increment sc on each tick; at the tick where sc==7, rxs=1 returns to IDLE (glitch rejected), rxs=0 goes to DATA with sc=0, bi=0.
REQ-020 DATA: SHALL sample rxs into shift bit bi (LSB first) on the tick where sc==15, then increment bi; after bi==7 is sampled, go to STOP with sc=0.
REQ-021 STOP: on the tick where sc==15, rxs=1 SHALL push the byte; rxs=0 SHALL set frame_err, discard the byte, and go to IDLE.
REQ-022 After STOP, the FSM SHALL return to IDLE; a new start requires a fresh falling edge.
REQ-023 rx_enable=0 in any non-IDLE state SHALL abort to IDLE next clk with no push and no flag change.
REQ-024 FIFO SHALL be 4 entries deep with 2-bit pointers wrapping 3->0 and a 3-bit count 0..4.
REQ-025 A push SHALL make rx_valid=1 on the clk after the stop-bit sample tick (1-clk latency).
REQ-026 rd_en=1 with count>0 SHALL advance the head on that clk; rd_en with count==0 SHALL be ignored (no underflow, pointers unchanged).
REQ-027 A push with count==4 and no simultaneous pop SHALL drop the new byte, keep FIFO contents, and set rx_overflow.
REQ-028 Simultaneous push and pop SHALL both take effect with count unchanged, including at count==4 (no overflow).
REQ-029 err_clr SHALL clear rx_overflow and frame_err next clk; a set event in the same clk SHALL win (flag stays 1).
REQ-030 rx_data SHALL be combinational from the head entry, gated to 8'h00 when count==0.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, sc=0, bi=0, tick counter 0, synchronizer flops=1, FIFO pointers/count=0, rx_valid=0, rx_data=8'h00, rx_overflow=0, frame_err=0, busy=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial byte; after release the next falling edge starts a new frame.

Verification (CLK_FREQ=640000, BAUD=10000 -> DIV=4, bit = 64 clk)
REQ-033 Send 8'hA5 with stop=1, rx_enable=1 -> rx_valid=1, rx_data=8'hA5, frame_err=0; rd_en one clk -> rx_valid=0, rx_data=8'h00.
REQ-034 Low pulse of 20 clk on rxd from idle -> FSM returns to IDLE, no push, busy drops, rx_valid=0.
REQ-035 Send 8'h3C with stop=0 -> frame_err=1, rx_valid=0; err_clr -> frame_err=0.
REQ-036 Send 8'h01..8'h05 without reading -> count=4, rx_overflow=1, pops return 01,02,03,04, then rx_valid=0.
REQ-037 FIFO full, rd_en asserted on the push clk of a 5th byte 8'h77 -> rx_overflow=0, pops return 02,03,04,77.
REQ-038 reset pulsed during bit 4 of a frame, then 8'h5A sent -> only 8'h5A is received; all flags=0.

Source files
------------

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line, FIFO read side and status flags of uart_receiver.
interface uart_receiver_if;
  logic       rxd;
  logic       rx_enable;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overflow;
  logic       frame_err;
  logic       busy;
  modport master (
    output rxd, rx_enable, rd_en, err_clr,
    input  rx_data, rx_valid, rx_overflow, frame_err, busy
  );
  modport slave (
    input  rxd, rx_enable, rd_en, err_clr,
    output rx_data, rx_valid, rx_overflow, frame_err, busy
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receiver with a 4-entry FIFO and sticky error flags.
module uart_receiver #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input logic           clk,
  input logic           reset,
  uart_receiver_if.slave bus
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e        state_q, state_d;
  logic          s1_q, s2_q, prev_q;
  logic [TW-1:0] tc_q;
  logic [3:0]    sc_q, sc_d;
  logic [2:0]    bi_q, bi_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    mem_q [4];
  logic [1:0]    wp_q, rp_q;
  logic [2:0]    cnt_q, cnt_d;
  logic          ovf_q, fe_q;
  logic          rxs, tick, fall, push, fe_set, pop, wr, ovf_set;
  assign rxs  = s2_q;
  assign tick = tc_q == TMAX;
  assign fall = prev_q & ~s2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      tc_q    <= '0;
      state_q <= IDLE;
      sc_q    <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      s1_q    <= bus.rxd;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      tc_q    <= tick ? '0 : tc_q + 1'b1;
      state_q <= state_d;
      sc_q    <= sc_d;
      bi_q    <= bi_d;
      sh_q    <= sh_d;
      if (wr) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_set | (ovf_q & ~bus.err_clr);
      fe_q    <= fe_set | (fe_q & ~bus.err_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= sh_q;
  end
  // Disabling the receiver mid-frame abandons the byte without touching the flags.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bi_d    = bi_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    if (state_q != IDLE && !bus.rx_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.rx_enable && fall) begin
          state_d = START;
          sc_d    = '0;
        end
        START: if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == 4'd7) begin
            state_d = rxs ? IDLE : DATA;
            sc_d    = '0;
            bi_d    = '0;
          end
        end
        DATA: if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == 4'd15) begin
            sh_d[bi_q] = rxs;
            bi_d       = bi_q + 1'b1;
            state_d    = bi_q == 3'd7 ? STOP : DATA;
          end
        end
        STOP: if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == 4'd15) begin
            state_d = IDLE;
            push    = rxs;
            fe_set  = ~rxs;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign pop     = bus.rd_en && cnt_q != 3'd0;
  assign wr      = push && (cnt_q != 3'd4 || pop);
  assign ovf_set = push && cnt_q == 3'd4 && !pop;
  assign cnt_d   = cnt_q + {2'b00, wr} - {2'b00, pop};
  assign bus.rx_data     = cnt_q != 3'd0 ? mem_q[rp_q] : 8'h00;
  assign bus.rx_valid    = cnt_q != 3'd0;
  assign bus.rx_overflow = ovf_q;
  assign bus.frame_err   = fe_q;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames checked every cycle against a timed behavioural model.
module tb_uart_receiver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  uart_receiver_if bus();
  uart_receiver #(.CLK_FREQ(640000), .BAUD(10000)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0;
  bit chk_en = 1'b0;
  logic [7:0] q[$];
  bit ovf_m, fe_m, busy_m;
  bit frame_on, fr_stop, fr_glitch, fr_pp;
  logic [7:0] fr_b;
  int fr_f, fr_p, fr_end, fr_abort;
  bit pop_req, clr_req, rand_io;
  // Line level after edge c: start bit, 8 data bits LSB first, stop bit, 64 clk each.
  function automatic logic line_level(int c);
    int o;
    o = c - fr_f;
    if (!frame_on || o < 0 || o >= 640) return 1'b1;
    if (fr_glitch) return o >= 20;
    return o < 64 ? 1'b0 : o < 576 ? fr_b[o/64-1] : fr_stop;
  endfunction
  task automatic step();
    bit pop, push;
    @(posedge clk);
    #1;
    cyc++;
    pop  = bus.rd_en && q.size() > 0;
    push = frame_on && !fr_glitch && fr_abort == 0 && cyc == fr_p;
    if (pop) void'(q.pop_front());
    if (bus.err_clr) begin
      ovf_m = 1'b0;
      fe_m  = 1'b0;
    end
    if (push && fr_stop) begin
      if (q.size() < 4) q.push_back(fr_b);
      else ovf_m = 1'b1;
    end
    if (push && !fr_stop) fe_m = 1'b1;
    busy_m = frame_on && cyc >= fr_f + 3 && cyc < fr_end;
    bus.rxd       = line_level(cyc);
    bus.rx_enable = !(frame_on && fr_abort != 0 && cyc >= fr_f + fr_abort && cyc < fr_f + 640);
    bus.rd_en     = pop_req || (frame_on && fr_pp && cyc == fr_p - 1) || (rand_io && $urandom_range(0, 99) < 4);
    bus.err_clr   = clr_req || (rand_io && $urandom_range(0, 199) == 0);
    pop_req = 1'b0;
    clr_req = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic pop_chk(input string n, input logic [7:0] exp);
    chk(n, bus.rx_data, exp);
    pop_req = 1'b1;
    step();
    step();
  endtask
  // Stop-bit sample falls on the 152nd tick after START entry; ticks land on edges that are multiples of 4.
  task automatic send(input logic [7:0] b, input bit stop, input bit glitch = 1'b0,
                      input int abort = 0, input bit pp = 1'b0, input int n = 660);
    int k0;
    fr_b      = b;
    fr_stop   = stop;
    fr_glitch = glitch;
    fr_abort  = abort;
    fr_pp     = pp;
    fr_f      = cyc + 1;
    k0        = ((fr_f + 3) / 4 + 1) * 4;
    fr_p      = k0 + 604;
    fr_end    = abort != 0 ? fr_f + abort + 1 : glitch ? k0 + 28 : fr_p;
    frame_on  = 1'b1;
    idle(n);
  endtask
  task automatic do_reset();
    chk_en        = 1'b0;
    reset         = 1'b1;
    bus.rxd       = 1'b1;
    bus.rx_enable = 1'b1;
    bus.rd_en     = 1'b0;
    bus.err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 8'(bus.busy), 8'h00);
    chk("rst_valid", 8'(bus.rx_valid), 8'h00);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_ovf", 8'(bus.rx_overflow), 8'h00);
    chk("rst_ferr", 8'(bus.frame_err), 8'h00);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cyc      = 0;
    q.delete();
    ovf_m    = 1'b0;
    fe_m     = 1'b0;
    busy_m   = 1'b0;
    frame_on = 1'b0;
    chk_en   = 1'b1;
  endtask
  always @(negedge clk) begin : cmp
    logic [11:0] got, exp;
    if (chk_en) begin
      got = {bus.busy, bus.rx_valid, bus.rx_overflow, bus.frame_err, bus.rx_data};
      exp = {busy_m, q.size() != 0, ovf_m, fe_m, q.size() != 0 ? q[0] : 8'h00};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL cycle %0d model_cmp {busy,valid,ovf,ferr,data}: got %h expected %h", cyc, got, exp);
      end
    end
  end
  initial begin
    #1;
    do_reset();
    idle(5);
    send(8'hA5, 1'b1);
    chk("a5_valid", 8'(bus.rx_valid), 8'h01);
    chk("a5_data", bus.rx_data, 8'hA5);
    chk("a5_ferr", 8'(bus.frame_err), 8'h00);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_empty_valid", 8'(bus.rx_valid), 8'h00);
    chk("a5_empty_data", bus.rx_data, 8'h00);
    send(8'h00, 1'b1, 1'b1);
    chk("glitch_busy", 8'(bus.busy), 8'h00);
    chk("glitch_valid", 8'(bus.rx_valid), 8'h00);
    send(8'h3C, 1'b0);
    chk("3c_ferr", 8'(bus.frame_err), 8'h01);
    chk("3c_valid", 8'(bus.rx_valid), 8'h00);
    clr_req = 1'b1;
    idle(2);
    chk("3c_ferr_clr", 8'(bus.frame_err), 8'h00);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    chk("full_ovf", 8'(bus.rx_overflow), 8'h01);
    for (int i = 1; i <= 4; i++) pop_chk("full_pop", 8'(i));
    chk("full_drained", 8'(bus.rx_valid), 8'h00);
    clr_req = 1'b1;
    idle(2);
    chk("ovf_clr", 8'(bus.rx_overflow), 8'h00);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    send(8'h77, 1'b1, 1'b0, 0, 1'b1);
    chk("pp_ovf", 8'(bus.rx_overflow), 8'h00);
    pop_chk("pp_pop0", 8'h02);
    pop_chk("pp_pop1", 8'h03);
    pop_chk("pp_pop2", 8'h04);
    pop_chk("pp_pop3", 8'h77);
    chk("pp_drained", 8'(bus.rx_valid), 8'h00);
    send(8'h96, 1'b1, 1'b0, 200);
    chk("abort_valid", 8'(bus.rx_valid), 8'h00);
    chk("abort_busy", 8'(bus.busy), 8'h00);
    send(8'hC3, 1'b1, 1'b0, 0, 1'b0, 350);
    do_reset();
    idle(7);
    send(8'h5A, 1'b1);
    chk("5a_data", bus.rx_data, 8'h5A);
    chk("5a_ovf", 8'(bus.rx_overflow), 8'h00);
    chk("5a_ferr", 8'(bus.frame_err), 8'h00);
    pop_chk("5a_pop", 8'h5A);
    chk("5a_drained", 8'(bus.rx_valid), 8'h00);
    rand_io = 1'b1;
    repeat (16) begin
      send(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
      idle($urandom_range(0, 30));
    end
    rand_io = 1'b0;
    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
